// File: rtl/display7seg_scan_if.sv
// rtl/display7seg_scan_if.sv - load/ack handshake between controller core and display driver
interface display7seg_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] Digits;
  logic [N_DIGITS-1:0]   Dp;
  logic                  Load;
  logic                  Ack;

  modport master (output Digits, output Dp, output Load, input Ack);
  modport slave  (input Digits, input Dp, input Load, output Ack);
endinterface

// File: rtl/display7seg_scan.sv
// rtl/display7seg_scan.sv - time-multiplexed common-anode 7-segment scanner with
// frame-aligned load commit, leading-zero blanking, blink and error override
module display7seg_scan #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  Clk,
  input  logic                  Rst,
  display7seg_scan_if.slave     load_bus,
  input  logic                  Lzb,
  input  logic                  Blink,
  input  logic                  ERRO,
  output logic [6:0]            SEGs,
  output logic                  SEG_P,
  output logic [N_DIGITS-1:0]   Dig
);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic [FRM_W-1:0]        frm;
  logic                    phase;
  logic                    pend;
  logic [4*N_DIGITS-1:0]   pend_digits;
  logic [N_DIGITS-1:0]     pend_dp;
  logic [4*N_DIGITS-1:0]   disp_digits;
  logic [N_DIGITS-1:0]     disp_dp;
  logic                    ack_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    commit;

  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    seen_nz;
  logic [N_DIGITS-1:0]     lz_blank;
  logic                    blank_cur;
  logic                    lit;
  logic [6:0]              seg_next;
  logic                    segp_next;
  logic [N_DIGITS-1:0]     dig_next;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] v);
    case (v)
      4'd0:    bcd_glyph = 7'h40;
      4'd1:    bcd_glyph = 7'h79;
      4'd2:    bcd_glyph = 7'h24;
      4'd3:    bcd_glyph = 7'h30;
      4'd4:    bcd_glyph = 7'h19;
      4'd5:    bcd_glyph = 7'h12;
      4'd6:    bcd_glyph = 7'h02;
      4'd7:    bcd_glyph = 7'h78;
      4'd8:    bcd_glyph = 7'h00;
      4'd9:    bcd_glyph = 7'h10;
      default: bcd_glyph = 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] err_glyph(input int d);
    case (d)
      0:       err_glyph = 7'h23;
      1:       err_glyph = 7'h2F;
      2:       err_glyph = 7'h2F;
      3:       err_glyph = 7'h06;
      default: err_glyph = 7'h7F;
    endcase
  endfunction

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign commit    = frame_end && (pend || load_bus.Load);
  assign load_bus.Ack = ack_q;

  always_comb begin
    nib       = 4'd0;
    dp_bit    = 1'b0;
    seen_nz   = 1'b0;
    lz_blank  = '0;
    blank_cur = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = disp_digits[4*i +: 4];
        dp_bit = disp_dp[i];
      end
    end
    // Walk from the leftmost digit; digit 0 always stays lit.
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (disp_digits[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      lz_blank[i] = !seen_nz;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) blank_cur = lz_blank[i];
    end

    lit = (int'(pre) >= GUARD) && !(Blink && !phase);
    if (ERRO) begin
      if (int'(idx) > 3) lit = 1'b0;
      seg_next  = err_glyph(int'(idx));
      segp_next = 1'b1;
    end else begin
      if (Lzb && blank_cur) lit = 1'b0;
      seg_next  = bcd_glyph(nib);
      segp_next = !dp_bit;
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      dig_next[i] = !(lit && (idx == IDX_W'(i)));
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pre         <= '0;
      idx         <= '0;
      frm         <= '0;
      phase       <= 1'b1;
      pend        <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
      ack_q       <= 1'b0;
      SEGs        <= 7'h7F;
      SEG_P       <= 1'b1;
      Dig         <= '1;
    end else begin
      pre <= slot_end ? '0 : pre + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;

      if (frame_end) begin
        if (frm == FRM_LAST) begin
          frm   <= '0;
          phase <= !phase;
        end else begin
          frm <= frm + 1'b1;
        end
      end

      if (load_bus.Load) begin
        pend_digits <= load_bus.Digits;
        pend_dp     <= load_bus.Dp;
      end

      // A Load in the boundary cycle bypasses the pending copy.
      if (commit) begin
        disp_digits <= load_bus.Load ? load_bus.Digits : pend_digits;
        disp_dp     <= load_bus.Load ? load_bus.Dp     : pend_dp;
        pend        <= 1'b0;
      end else if (load_bus.Load) begin
        pend <= 1'b1;
      end

      ack_q <= commit;
      SEGs  <= seg_next;
      SEG_P <= segp_next;
      Dig   <= dig_next;
    end
  end
endmodule

// File: tb/tb_display7seg_scan.sv
// tb/tb_display7seg_scan.sv - bench for display7seg_scan: cycle model plus directed
// literal checks of load, collision, blanking, error and blink behaviour
module tb_display7seg_scan;
  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int G     = 1;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic       Clk   = 1'b0;
  logic       Rst   = 1'b0;
  logic       Lzb   = 1'b0;
  logic       Blink = 1'b0;
  logic       ERRO  = 1'b0;
  logic [6:0] SEGs;
  logic       SEG_P;
  logic [3:0] Dig;

  display7seg_scan_if #(.N_DIGITS(N)) load_bus ();

  display7seg_scan #(
    .N_DIGITS(N), .SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Rst(Rst), .load_bus(load_bus), .Lzb(Lzb), .Blink(Blink),
    .ERRO(ERRO), .SEGs(SEGs), .SEG_P(SEG_P), .Dig(Dig)
  );

  initial forever #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] err_glyph(input int d);
    case (d)
      3: return 7'h06;
      2: return 7'h2F;
      1: return 7'h2F;
      default: return 7'h23;
    endcase
  endfunction

  // Model state: t counts cycles since reset release; scan position is derived from it.
  int         t      = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pdig = '0;
  logic [3:0]  m_dp   = '0;
  logic [3:0]  m_pdp  = '0;
  logic        m_pend = 1'b0;
  logic [6:0]  e_seg  = 7'h7F;
  logic        e_sp   = 1'b1;
  logic [3:0]  e_dig  = 4'hF;
  logic        e_ack  = 1'b0;

  initial forever begin
    int pre, idx, frame, nib;
    bit on, lit, bnd;
    @(posedge Clk or negedge Rst);
    if (!Rst) begin
      t = 0; m_disp = '0; m_pdig = '0; m_dp = '0; m_pdp = '0; m_pend = 1'b0;
      e_seg = 7'h7F; e_sp = 1'b1; e_dig = 4'hF; e_ack = 1'b0;
    end else begin
      pre   = t % SD;
      idx   = (t / SD) % N;
      frame = t / FRAME;
      on    = ((frame / BF) % 2) == 0;
      bnd   = (t % FRAME) == FRAME - 1;
      lit   = (pre >= G) && !(Blink && !on);
      if (ERRO) begin
        if (idx >= 4) lit = 0;
        e_seg = err_glyph(idx);
        e_sp  = 1'b1;
      end else begin
        nib = int'((m_disp >> (4 * idx)) & 16'hF);
        if (Lzb && idx > 0 && (m_disp >> (4 * idx)) == 16'h0) lit = 0;
        e_seg = glyph(nib);
        e_sp  = !m_dp[idx];
      end
      e_dig = 4'hF;
      if (lit) e_dig[idx] = 1'b0;
      if (load_bus.Load) begin
        m_pdig = load_bus.Digits;
        m_pdp  = load_bus.Dp;
        m_pend = 1'b1;
      end
      e_ack = bnd && m_pend;
      if (e_ack) begin
        m_disp = m_pdig;
        m_dp   = m_pdp;
        m_pend = 1'b0;
      end
      t++;
    end
  end

  initial forever begin
    @(negedge Clk);
    check("model_dig", Dig, e_dig);
    check("model_ack", load_bus.Ack, e_ack);
    if (!Rst || e_dig != 4'hF) begin
      check("model_segs", SEGs, e_seg);
      check("model_segp", SEG_P, e_sp);
    end
  end

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    @(posedge Clk); #1;
    load_bus.Digits = d;
    load_bus.Dp     = p;
    load_bus.Load   = 1'b1;
    @(posedge Clk); #1;
    load_bus.Load   = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge Clk);
      seen = load_bus.Ack;
    end
    check(name, seen, 1);
  endtask

  task automatic count_ack(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (load_bus.Ack) n++;
    end
  endtask

  task automatic count_lit(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (Dig != 4'hF) n++;
    end
  endtask

  task automatic wait_dig(input string name, input logic [3:0] target,
                          input logic [6:0] seg, input logic sp);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      found = (Dig == target);
    end
    check({name, "_found"}, found, 1);
    if (found) begin
      check({name, "_segs"}, SEGs, seg);
      check({name, "_segp"}, SEG_P, sp);
    end
  endtask

  // Returns at the negedge showing the slot-0 guard cycle of a frame.
  task automatic align_slot0();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      found = (Dig == 4'h7);
    end
    check("align_slot3", found, 1);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge Clk);
      found = (Dig == 4'hF);
    end
    check("align_guard", found, 1);
  endtask

  initial begin
    int n;
    load_bus.Digits = '0;
    load_bus.Dp     = '0;
    load_bus.Load   = 1'b0;

    repeat (4) begin
      @(posedge Clk); #1;
      load_bus.Digits = 16'($urandom);
      load_bus.Dp     = 4'($urandom);
      load_bus.Load   = 1'($urandom);
      Lzb   = 1'($urandom);
      Blink = 1'($urandom);
      ERRO  = 1'($urandom);
    end
    @(negedge Clk);
    check("rst_segs", SEGs, 7'h7F);
    check("rst_segp", SEG_P, 1'b1);
    check("rst_dig", Dig, 4'hF);
    check("rst_ack", load_bus.Ack, 1'b0);
    @(posedge Clk); #1;
    load_bus.Digits = '0; load_bus.Dp = '0; load_bus.Load = 1'b0;
    Lzb = 0; Blink = 0; ERRO = 0;
    Rst = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("rel_guard", Dig, 4'hF);
    end
    @(negedge Clk);
    check("rel_first_lit", Dig, 4'hE);

    load(16'h1234, 4'b0010);
    wait_ack("ack_1234", 40);
    @(negedge Clk); check("s0_guard", Dig, 4'hF);
    @(negedge Clk); check("s0_dig", Dig, 4'hE);
    check("s0_segs", SEGs, 7'h19);
    check("s0_segp", SEG_P, 1'b1);
    repeat (2) @(negedge Clk);
    @(negedge Clk); check("s1_guard", Dig, 4'hF);
    @(negedge Clk); check("s1_dig", Dig, 4'hD);
    check("s1_segs", SEGs, 7'h30);
    check("s1_segp", SEG_P, 1'b0);

    load(16'h1111, 4'b0000);
    load(16'h2222, 4'b0000);
    count_ack(20, n);
    check("collide_one_ack", n, 1);
    wait_dig("collide_d0", 4'hE, 7'h24, 1'b1);

    align_slot0();
    repeat (14) @(posedge Clk);
    #1;
    load_bus.Digits = 16'h5678;
    load_bus.Load   = 1'b1;
    @(posedge Clk); #1;
    load_bus.Load   = 1'b0;
    @(negedge Clk);
    check("bnd_ack", load_bus.Ack, 1'b1);
    count_ack(20, n);
    check("bnd_no_second_ack", n, 0);
    wait_dig("bnd_d0", 4'hE, 7'h00, 1'b1);

    Lzb = 1'b1;
    load(16'h0050, 4'b0000);
    wait_ack("ack_0050", 40);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge Clk);
      if (Dig[3] == 1'b0 || Dig[2] == 1'b0) n++;
    end
    check("lzb_hi_blank", n, 0);
    wait_dig("lzb_d1", 4'hD, 7'h12, 1'b1);
    wait_dig("lzb_d0", 4'hE, 7'h40, 1'b1);
    load(16'h000B, 4'b0000);
    wait_ack("ack_000b", 40);
    wait_dig("dash_d0", 4'hE, 7'h3F, 1'b1);

    ERRO = 1'b1;
    load(16'h0000, 4'hF);
    wait_ack("ack_err", 40);
    wait_dig("err_d3", 4'h7, 7'h06, 1'b1);
    wait_dig("err_d2", 4'hB, 7'h2F, 1'b1);
    wait_dig("err_d1", 4'hD, 7'h2F, 1'b1);
    wait_dig("err_d0", 4'hE, 7'h23, 1'b1);
    @(posedge Clk); #1;
    ERRO = 1'b0;
    Lzb  = 1'b0;

    @(posedge Clk); #1;
    Blink = 1'b1;
    @(negedge Clk);
    count_lit(64, n);
    check("blink_lit_64", n, 24);
    @(posedge Clk); #1;
    Blink = 1'b0;
    @(negedge Clk);
    count_lit(16, n);
    check("unblink_lit_16", n, 12);

    align_slot0();
    load(16'h9999, 4'b0000);
    @(posedge Clk); #1;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    count_ack(40, n);
    check("midrst_no_ack", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
